// File: rtl/shadow_return_stack.sv
// ============================================================================
//  Module      : shadow_return_stack
//  Description : Hardware shadow stack that checks committed returns against
//                the link addresses pushed by committed calls.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shadow_return_stack #(
  parameter int DEPTH = 16,
  parameter int VLEN  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic                       debug_mode_i,
  input  logic                       valid_i,
  input  logic                       is_call_i,
  input  logic                       is_return_i,
  input  logic [VLEN-1:0]            pc_i,
  input  logic                       is_compressed_i,
  input  logic [VLEN-1:0]            target_i,
  input  logic                       clear_i,
  output logic                       violation_o,
  output logic [VLEN-1:0]            violation_pc_o,
  output logic [VLEN-1:0]            violation_expected_o,
  output logic [$clog2(DEPTH):0]     depth_o,
  output logic                       overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [VLEN-1:0] stack_q [DEPTH];
  logic [PW-1:0]   tp_q, tp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            violation_q, violation_d;
  logic [VLEN-1:0] vpc_q, vpc_d;
  logic [VLEN-1:0] vexp_q, vexp_d;
  logic            overflow_q, overflow_d;

  logic            act, do_call, do_ret, ret_pop, viol, ovf;
  logic [PW-1:0]   tp_popped;
  logic [CW-1:0]   cnt_popped;
  logic [VLEN-1:0] top_entry, link;

  assign act       = valid_i & ~debug_mode_i;
  assign do_call   = act & is_call_i;
  assign do_ret    = act & is_return_i;
  assign top_entry = stack_q[tp_q - PW'(1)];
  assign link      = pc_i + (is_compressed_i ? VLEN'(2) : VLEN'(4));

  // Underflowing returns are silently dropped: no compare, no pop.
  assign ret_pop    = do_ret && (cnt_q != '0);
  assign viol       = ret_pop && en_i && (target_i != top_entry);
  assign tp_popped  = ret_pop ? tp_q - PW'(1) : tp_q;
  assign cnt_popped = ret_pop ? cnt_q - CW'(1) : cnt_q;
  // A call on a stack that is still full after the return part loses an entry.
  assign ovf        = do_call && (cnt_popped == FULL);

  always_comb begin
    tp_d        = tp_popped;
    cnt_d       = cnt_popped;
    violation_d = violation_q;
    vpc_d       = vpc_q;
    vexp_d      = vexp_q;
    overflow_d  = overflow_q;

    if (do_call) begin
      tp_d = tp_popped + PW'(1);
      if (cnt_popped != FULL) begin
        cnt_d = cnt_popped + CW'(1);
      end
    end

    if (viol) begin
      violation_d = 1'b1;
      if (!violation_q) begin
        vpc_d  = pc_i;
        vexp_d = top_entry;
      end
    end else if (clear_i) begin
      violation_d = 1'b0;
    end

    if (ovf) begin
      overflow_d = 1'b1;
    end else if (clear_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tp_q        <= '0;
      cnt_q       <= '0;
      violation_q <= 1'b0;
      vpc_q       <= '0;
      vexp_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      tp_q        <= tp_d;
      cnt_q       <= cnt_d;
      violation_q <= violation_d;
      vpc_q       <= vpc_d;
      vexp_q      <= vexp_d;
      overflow_q  <= overflow_d;
    end
  end

  // Entry contents need no reset; cnt_q alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_call) begin
      stack_q[tp_popped] <= link;
    end
  end

  assign violation_o          = violation_q;
  assign violation_pc_o       = vpc_q;
  assign violation_expected_o = vexp_q;
  assign depth_o              = cnt_q;
  assign overflow_o           = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_shadow_return_stack.sv
// ============================================================================
//  Module      : tb_shadow_return_stack
//  Description : Randomised scoreboard bench for shadow_return_stack.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shadow_return_stack;

  localparam int DEPTH = 16;
  localparam int VLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b1, dbg = 1'b0, valid = 1'b0, is_call = 1'b0, is_ret = 1'b0;
  logic [VLEN-1:0] pc = '0, tgt = '0;
  logic            comp = 1'b0, clr = 1'b0;
  logic            viol_o, ovf_o;
  logic [VLEN-1:0] vpc_o, vexp_o;
  logic [CW-1:0]   depth_o;

  shadow_return_stack #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .en_i                 (en),
    .debug_mode_i         (dbg),
    .valid_i              (valid),
    .is_call_i            (is_call),
    .is_return_i          (is_ret),
    .pc_i                 (pc),
    .is_compressed_i      (comp),
    .target_i             (tgt),
    .clear_i              (clr),
    .violation_o          (viol_o),
    .violation_pc_o       (vpc_o),
    .violation_expected_o (vexp_o),
    .depth_o              (depth_o),
    .overflow_o           (ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            v;
    logic [VLEN-1:0] vpc;
    logic [VLEN-1:0] vexp;
    int              d;
    logic            o;
    int              due;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  // Reference model: a plain list of return addresses, newest at the back.
  logic [VLEN-1:0] mstk[$];
  logic            mviol = 1'b0, movf = 1'b0;
  logic [VLEN-1:0] mvpc = '0, mvexp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: compares every DUT output once the event it belongs to has taken effect.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      chk("violation", 64'(viol_o), 64'(e.v));
      chk("violation_pc", 64'(vpc_o), 64'(e.vpc));
      chk("violation_expected", 64'(vexp_o), 64'(e.vexp));
      chk("depth", 64'(depth_o), 64'(e.d));
      chk("overflow", 64'(ovf_o), 64'(e.o));
    end
  end

  task automatic model_reset();
    mstk.delete();
    mviol = 1'b0; movf = 1'b0; mvpc = '0; mvexp = '0;
  endtask

  task automatic ev(input bit v, input bit c, input bit r, input logic [VLEN-1:0] p,
                    input bit cm, input logic [VLEN-1:0] t, input bit e, input bit d,
                    input bit cl);
    bit              hit = 1'b0;
    bit              ovh = 1'b0;
    logic [VLEN-1:0] top = '0;
    exp_t            x;
    @(posedge clk); #1;
    valid = v; is_call = c; is_ret = r; pc = p; comp = cm; tgt = t;
    en = e; dbg = d; clr = cl;
    if (v && !d) begin
      if (r && mstk.size() > 0) begin
        top = mstk.pop_back();
        if (top != t && e) hit = 1'b1;
      end
      if (c) begin
        if (mstk.size() == DEPTH) begin
          void'(mstk.pop_front());
          ovh = 1'b1;
        end
        mstk.push_back(p + (cm ? 32'd2 : 32'd4));
      end
    end
    if (hit) begin
      if (!mviol) begin mvpc = p; mvexp = top; end
      mviol = 1'b1;
    end else if (cl) mviol = 1'b0;
    if (ovh) movf = 1'b1;
    else if (cl) movf = 1'b0;
    x.v = mviol; x.vpc = mvpc; x.vexp = mvexp; x.d = mstk.size(); x.o = movf; x.due = cyc + 1;
    exp_q.push_back(x);
  endtask

  task automatic call(input logic [VLEN-1:0] p, input bit cm);
    ev(1, 1, 0, p, cm, '0, 1, 0, 0);
  endtask
  task automatic ret(input logic [VLEN-1:0] p, input logic [VLEN-1:0] t, input bit e);
    ev(1, 0, 1, p, 0, t, e, 0, 0);
  endtask
  task automatic idle(input bit cl);
    ev(0, 0, 0, '0, 0, '0, 1, 0, cl);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, pending %0d", exp_q.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("reset_violation", 64'(viol_o), 64'd0);
    chk("reset_depth", 64'(depth_o), 64'd0);
    chk("reset_overflow", 64'(ovf_o), 64'd0);
    #10 rst_n = 1'b1;
    idle(0);

    // Matched call/return.
    call(32'h8000_0100, 0);
    ret(32'h8000_0500, 32'h8000_0104, 1);

    // Mismatch, second mismatch keeps the first capture, then clear.
    call(32'h8000_0200, 1);
    ret(32'h8000_0210, 32'h8000_0300, 1);
    call(32'h8000_0220, 0);
    ret(32'h8000_0230, 32'h0000_0000, 1);
    idle(1);

    // Checking disabled: mismatch ignored, pop still happens.
    call(32'h8000_0200, 1);
    ret(32'h8000_0210, 32'h8000_0300, 0);

    // Overflow, draining in order, then underflow.
    for (int k = 0; k <= DEPTH; k++) call(32'h1000 + 32'(16 * k), 0);
    for (int k = DEPTH; k >= 1; k--) ret(32'h5000, 32'h1000 + 32'(16 * k) + 32'd4, 1);
    ret(32'h5000, 32'hdead_beef, 1);
    idle(1);

    // Co-routine swap.
    call(32'h2000, 0);
    ev(1, 1, 1, 32'h3000, 0, 32'h2004, 1, 0, 0);
    ret(32'h3100, 32'h3004, 1);
    // Swap on an empty stack behaves as a plain push.
    ev(1, 1, 1, 32'h3200, 1, 32'h1111, 1, 0, 0);
    ret(32'h3300, 32'h3202, 1);

    // Debug mode holds state.
    call(32'h4000, 0);
    ev(1, 1, 0, 32'h4100, 0, '0, 1, 1, 0);
    ev(1, 0, 1, 32'h4200, 0, 32'h9999, 1, 1, 0);
    ret(32'h4300, 32'h4004, 1);

    // Asynchronous reset mid-sequence.
    for (int k = 0; k <= DEPTH; k++) call(32'h6000 + 32'(8 * k), 0);
    ret(32'h7000, 32'h0, 1);
    idle(0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_violation", 64'(viol_o), 64'd0);
    chk("async_vpc", 64'(vpc_o), 64'd0);
    chk("async_vexp", 64'(vexp_o), 64'd0);
    chk("async_depth", 64'(depth_o), 64'd0);
    chk("async_overflow", 64'(ovf_o), 64'd0);
    model_reset();
    #1 rst_n = 1'b1;
    ret(32'h7100, 32'h1234, 1);
    call(32'h7200, 1);
    ret(32'h7300, 32'h7202, 1);

    // Random traffic; returns often target the true top to exercise pops deeply.
    for (int i = 0; i < 3000; i++) begin
      bit              c, r, cm, e, d, cl, v;
      logic [VLEN-1:0] p, t;
      v  = ($urandom_range(0, 9) != 0);
      c  = ($urandom_range(0, 1) == 1);
      r  = ($urandom_range(0, 2) == 0) || (!c);
      cm = $urandom_range(0, 1);
      e  = ($urandom_range(0, 7) != 0);
      d  = ($urandom_range(0, 19) == 0);
      cl = ($urandom_range(0, 29) == 0);
      p  = $urandom;
      if (mstk.size() > 0 && $urandom_range(0, 9) != 0) t = mstk[mstk.size() - 1];
      else t = $urandom;
      ev(v, c, r, p, cm, t, e, d, cl);
    end
    idle(0);

    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
